// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N-channel stream multiplexer with valid/ready
// handshakes. The channel is picked either by the sel port (MODE=0) or by a
// round-robin arbiter (MODE=1). A single output register gives 1-cycle
// latency and full throughput.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int MODE     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  input  logic [CHANNELS-1:0]         in_valid,
  output logic [CHANNELS-1:0]         in_ready,
  input  logic [SEL_W-1:0]            sel,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SEL_W-1:0]            out_chan
);

  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] chan_q;
  logic             valid_q;
  logic [SEL_W-1:0] ptr_q;

  logic             gnt_vld;
  logic [SEL_W-1:0] gnt;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

  // Grant: explicit select, or first valid channel after the rr pointer.
  // An out-of-range sel never matches any channel index, so it never grants.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    if (MODE == 0) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (SEL_W'(i) == sel && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(i);
        end
      end
    end else begin
      for (int k = CHANNELS; k >= 1; k--) begin
        // Walk from the farthest candidate back to the nearest so the
        // nearest valid channel after ptr_q wins.
        if (in_valid[(int'(ptr_q) + k) % CHANNELS]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'((int'(ptr_q) + k) % CHANNELS);
        end
      end
    end
  end

  assign can_load = !valid_q || out_ready;
  assign xfer     = can_load && gnt_vld && !rst;
  assign mux_data = in_data[int'(gnt)*WIDTH +: WIDTH];

  // Ready is one-hot on the granted channel, only when the register can load.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (xfer && gnt == SEL_W'(i)) in_ready[i] = 1'b1;
    end
  end

  // Output register: load on transfer, drain on consume, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= SEL_W'(CHANNELS - 1);
    end else begin
      if (xfer) begin
        data_q  <= mux_data;
        chan_q  <= gnt;
        valid_q <= 1'b1;
        ptr_q   <= gnt;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr: one instance per selection mode, directed
// stimulus with expected words queued by the driver and checked by a monitor
// whenever the output handshake completes.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // ---------------- MODE=0 instance ----------------
  logic            a_rst;
  logic [3:0][7:0] a_data;
  logic [3:0]      a_valid, a_ready;
  logic [1:0]      a_sel, a_chan;
  logic [7:0]      a_odata;
  logic            a_ovalid, a_oready;
  logic [9:0]      a_q[$];

  stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_a (
    .clk(clk), .rst(a_rst), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .sel(a_sel), .out_data(a_odata),
    .out_valid(a_ovalid), .out_ready(a_oready), .out_chan(a_chan)
  );

  // ---------------- MODE=1 instance ----------------
  logic            b_rst;
  logic [3:0][7:0] b_data;
  logic [3:0]      b_valid, b_ready;
  logic [1:0]      b_sel, b_chan;
  logic [7:0]      b_odata;
  logic            b_ovalid, b_oready;
  logic [9:0]      b_q[$];

  stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_b (
    .clk(clk), .rst(b_rst), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .sel(b_sel), .out_data(b_odata),
    .out_valid(b_ovalid), .out_ready(b_oready), .out_chan(b_chan)
  );

  // Monitors: each completed output handshake must match the queue head.
  always @(negedge clk) begin
    if (!a_rst && a_ovalid && a_oready) begin
      if (a_q.size() == 0) chk("a_unexpected_word", {22'd0, a_chan, a_odata}, 32'hFFFF);
      else chk("a_word", {22'd0, a_chan, a_odata}, {22'd0, a_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!b_rst && b_ovalid && b_oready) begin
      if (b_q.size() == 0) chk("b_unexpected_word", {22'd0, b_chan, b_odata}, 32'hFFFF);
      else chk("b_word", {22'd0, b_chan, b_odata}, {22'd0, b_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_valid = 4'b1111; a_oready = 1'b1; a_sel = 2'd0;
    b_rst = 1'b1; b_valid = 4'b1111; b_oready = 1'b1; b_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      a_data[i] = 8'h50 + 8'(i);
      b_data[i] = 8'h10 + 8'(i);
    end

    // Reset held two cycles with all inputs valid.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("a_rst_valid", {31'd0, a_ovalid}, 32'd0);
      chk("a_rst_data",  {24'd0, a_odata},  32'd0);
      chk("a_rst_chan",  {30'd0, a_chan},   32'd0);
      chk("a_rst_ready", {28'd0, a_ready},  32'd0);
      chk("b_rst_valid", {31'd0, b_ovalid}, 32'd0);
      chk("b_rst_ready", {28'd0, b_ready},  32'd0);
    end

    // ---------- MODE=0 explicit select ----------
    a_rst = 1'b0; a_sel = 2'd2; a_valid = 4'b0100; a_data[2] = 8'hA5;
    #1;
    chk("a_sel2_ready", {28'd0, a_ready}, 32'h4);
    a_q.push_back({2'd2, 8'hA5});
    tick();
    chk("a_sel2_valid", {31'd0, a_ovalid}, 32'd1);
    chk("a_sel2_data",  {24'd0, a_odata},  32'hA5);
    chk("a_sel2_chan",  {30'd0, a_chan},   32'd2);
    a_sel = 2'd1;  // channel 1 not valid
    #1;
    chk("a_sel1_noready", {28'd0, a_ready}, 32'd0);
    tick();
    chk("a_drained", {31'd0, a_ovalid}, 32'd0);

    // Backpressure: hold 3C for three cycles while inputs churn.
    a_sel = 2'd0; a_valid = 4'b0001; a_data[0] = 8'h3C;
    a_q.push_back({2'd0, 8'h3C});
    tick();
    a_oready = 1'b0; a_sel = 2'd3; a_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      a_data[3] = 8'h70 + 8'(c);
      a_data[0] = 8'hE0 + 8'(c);
      #1;
      chk("a_stall_ready", {28'd0, a_ready}, 32'd0);
      tick();
      chk("a_stall_valid", {31'd0, a_ovalid}, 32'd1);
      chk("a_stall_data",  {24'd0, a_odata},  32'h3C);
      chk("a_stall_chan",  {30'd0, a_chan},   32'd0);
    end
    a_oready = 1'b1; a_data[3] = 8'h77;
    #1;
    chk("a_release_ready", {28'd0, a_ready}, 32'h8);
    a_q.push_back({2'd3, 8'h77});
    tick();
    chk("a_reload_valid", {31'd0, a_ovalid}, 32'd1);
    chk("a_reload_data",  {24'd0, a_odata},  32'h77);
    a_valid = 4'b0000;
    tick();
    chk("a_final_empty", {31'd0, a_ovalid}, 32'd0);

    // ---------- MODE=1 round-robin fairness ----------
    b_rst = 1'b0;
    for (int k = 0; k < 8; k++) b_q.push_back({2'(k % 4), 8'h10 + 8'(k % 4)});
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b_rr_chan", {30'd0, b_chan}, 32'(k % 4));
    end

    // Skip and wrap: pointer sits at 3.
    b_valid = 4'b0010;
    #1;
    chk("b_skip_ready", {28'd0, b_ready}, 32'h2);
    b_q.push_back({2'd1, 8'h11});
    tick();
    b_valid = 4'b1001;  // ptr=1, search 2,3 -> ch3
    #1;
    chk("b_wrap_ready3", {28'd0, b_ready}, 32'h8);
    b_q.push_back({2'd3, 8'h13});
    tick();
    #1;  // ptr=3, search wraps to ch0
    chk("b_wrap_ready0", {28'd0, b_ready}, 32'h1);
    b_q.push_back({2'd0, 8'h10});
    tick();

    // Reset while stalled discards the held word and the pointer.
    b_valid = 4'b0010;
    b_q.push_back({2'd1, 8'h11});
    tick();
    b_oready = 1'b0; b_valid = 4'b0000;
    tick();
    chk("b_hold_valid", {31'd0, b_ovalid}, 32'd1);
    chk("b_hold_chan",  {30'd0, b_chan},   32'd1);
    b_rst = 1'b1;
    tick();
    chk("b_midrst_valid", {31'd0, b_ovalid}, 32'd0);
    chk("b_midrst_data",  {24'd0, b_odata},  32'd0);
    b_q.delete();
    b_rst = 1'b0; b_oready = 1'b1; b_valid = 4'b1111;
    #1;
    chk("b_postrst_ready", {28'd0, b_ready}, 32'h1);
    b_q.push_back({2'd0, 8'h10});
    tick();
    chk("b_postrst_chan", {30'd0, b_chan}, 32'd0);
    b_valid = 4'b0000;
    tick();
    tick();

    chk("a_queue_empty", 32'(a_q.size()), 32'd0);
    chk("b_queue_empty", 32'(b_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
